seq_bit_serializer: RTL

//   Upstream feeder for the 1011 sequence detector. Accepts parallel words over a

---
 rtl/seq_bit_serializer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1011 sequence detector: valid/ready word input,
// one-word holding register for gapless streaming, one bit per BIT_DIV clocks on bit_out.
module seq_bit_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned BIT_DIV    = 1,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic xfer;
  logic tick;
  logic last_bit;
  logic word_end;

  // The bit on the line is always the head of the shift register.
  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign xfer     = din_valid & ~hold_full_q;
  assign tick     = (div_q == DIV_LAST);
  assign last_bit = (idx_q == IDX_LAST);
  assign word_end = (state_q == ST_SHIFT) & tick & last_bit;

  assign din_ready  = ~hold_full_q;
  assign frame_done = word_end;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign frame_cnt  = cnt_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    div_d       = div_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_SHIFT;
          shreg_d = din;
          div_d   = '0;
          idx_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (!tick) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (last_bit) begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = '0;
            // Held word takes priority; ready is low then, so no transfer can collide.
            if (hold_full_q) begin
              shreg_d     = hold_q;
              hold_full_d = 1'b0;
            end else if (xfer) begin
              shreg_d = din;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shift_next(shreg_q);
          end
        end
        if (xfer && !(tick && last_bit)) begin
          hold_d      = din;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_SHIFT);
    bit_valid_d = busy_d;
    bit_out_d   = busy_d ? head_bit(shreg_d) : IDLE_LEVEL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      bit_out_q   <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule
